// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants, capture FSM state type and level helper
// Purpose: constants common to the servo PWM generator and the capture block.
// Contents: pwm_state_e (IDLE/HIGH/LOW/STUCK), PWM_PERIOD_CYC, PWM_LEVEL_SHIFT,
//           PWM_TIMEOUT_CYC, pwm_sat_level().
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } pwm_state_e;

    localparam int PWM_PERIOD_CYC  = 1_000_001;
    localparam int PWM_LEVEL_SHIFT = 18;
    localparam int PWM_TIMEOUT_CYC = 2_000_000;

    // Clamp an already-shifted high time onto the 0-15 level scale.
    function automatic logic [3:0] pwm_sat_level(input logic [31:0] shifted);
        return (shifted > 32'd15) ? 4'd15 : shifted[3:0];
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - 2-flop synchronizer plus delay flop with edge strobes
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   async_in    : asynchronous input line
//   sync        : synchronized level (second flop)
//   rise, fall  : one-cycle strobes derived from sync vs. its delayed copy
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high time of an external PWM line
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pwm_in        : asynchronous PWM line
//   period_o      : last complete period (rising to rising) in cycles
//   high_o        : high time of that period in cycles
//   level_o       : min(high_o >> LEVEL_SHIFT, 15)
//   meas_valid_o  : one-cycle pulse when period_o/high_o/level_o update
//   stuck_o       : no rising edge for TIMEOUT_CYC cycles
//   pwm_sync_o    : synchronized pwm_in level
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 21,
    parameter int TIMEOUT_CYC = PWM_TIMEOUT_CYC,
    parameter int LEVEL_SHIFT = PWM_LEVEL_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic [3:0]       level_o,
    output logic             meas_valid_o,
    output logic             stuck_o,
    output logic             pwm_sync_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    logic             rise, fall;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] high_tmp;
    logic             timeout;
    logic             latch_high;
    logic             capture;
    pwm_state_e       state, state_nxt;

    pwm_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pwm_in),
        .sync     (pwm_sync_o),
        .rise     (rise),
        .fall     (fall)
    );

    // A rise in the saturation cycle wins: it is a valid period of TIMEOUT_CYC.
    assign timeout = (p_cnt == TIMEOUT_V) && !rise;

    // Counts cycles since the last rise; holds at TIMEOUT_CYC so it doubles as the stuck detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_cnt <= '0;
        end else if (rise) begin
            p_cnt <= CNT_W'(1);
        end else if (p_cnt != TIMEOUT_V) begin
            p_cnt <= p_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = STUCK;
            end
            HIGH: begin
                if (fall)         state_nxt = LOW;
                else if (timeout) state_nxt = STUCK;
            end
            LOW: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = STUCK;
            end
            STUCK: begin
                if (rise)         state_nxt = HIGH;
                else if (fall)    state_nxt = IDLE;
            end
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stuck_o    = (state == STUCK);
        latch_high = (state == HIGH) && fall;
        capture    = (state == LOW) && rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_tmp     <= '0;
            period_o     <= '0;
            high_o       <= '0;
            level_o      <= '0;
            meas_valid_o <= 1'b0;
        end else begin
            meas_valid_o <= capture;
            if (latch_high) begin
                high_tmp <= p_cnt;
            end
            if (capture) begin
                period_o <= p_cnt;
                high_o   <= high_tmp;
                level_o  <= pwm_sat_level(32'(high_tmp >> LEVEL_SHIFT));
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture (CNT_W=8, TIMEOUT_CYC=100, LEVEL_SHIFT=2)
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] period_o;
    logic [7:0] high_o;
    logic [3:0] level_o;
    logic       meas_valid_o;
    logic       stuck_o;
    logic       pwm_sync_o;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int pulses;
    int first_pulse_cyc;
    int stuck_first_cyc;
    bit stuck_seen;
    logic [7:0] last_period;
    logic [7:0] last_high;
    logic [3:0] last_level;

    pwm_capture #(
        .CNT_W       (8),
        .TIMEOUT_CYC (100),
        .LEVEL_SHIFT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .period_o     (period_o),
        .high_o       (high_o),
        .level_o      (level_o),
        .meas_valid_o (meas_valid_o),
        .stuck_o      (stuck_o),
        .pwm_sync_o   (pwm_sync_o)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        pulses          = 0;
        first_pulse_cyc = -1;
        stuck_first_cyc = -1;
        stuck_seen      = 1'b0;
    endtask

    // Hold pwm_in at lvl for n clock edges, recording pulses and stuck events 1 ns after each edge.
    task automatic drive(input logic lvl, input int n);
        pwm_in = lvl;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (meas_valid_o) begin
                pulses++;
                if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
                last_period = period_o;
                last_high   = high_o;
                last_level  = level_o;
            end
            if (stuck_o) begin
                if (!stuck_seen) stuck_first_cyc = cyc;
                stuck_seen = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        clear_mon();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++; if (period_o !== 8'd0)     begin err_cnt++; $display("FAIL reset_period: got %0d want 0", period_o); end
        cmp_cnt++; if (high_o !== 8'd0)       begin err_cnt++; $display("FAIL reset_high: got %0d want 0", high_o); end
        cmp_cnt++; if (level_o !== 4'd0)      begin err_cnt++; $display("FAIL reset_level: got %0d want 0", level_o); end
        cmp_cnt++; if (meas_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", meas_valid_o); end
        cmp_cnt++; if (stuck_o !== 1'b0)      begin err_cnt++; $display("FAIL reset_stuck: got %b want 0", stuck_o); end
        cmp_cnt++; if (pwm_sync_o !== 1'b0)   begin err_cnt++; $display("FAIL reset_sync: got %b want 0", pwm_sync_o); end
    endtask

    task automatic test_steady();
        int c0;
        do_reset();
        drive(1'b0, 5);
        c0 = cyc;
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, 10);
            drive(1'b0, 30);
        end
        cmp_cnt++; if (first_pulse_cyc != c0 + 43) begin err_cnt++; $display("FAIL steady_first_pulse_cycle: got %0d want %0d", first_pulse_cyc, c0 + 43); end
        cmp_cnt++; if (pulses != 4)            begin err_cnt++; $display("FAIL steady_pulse_count: got %0d want 4", pulses); end
        cmp_cnt++; if (last_period !== 8'd40)  begin err_cnt++; $display("FAIL steady_period: got %0d want 40", last_period); end
        cmp_cnt++; if (last_high !== 8'd10)    begin err_cnt++; $display("FAIL steady_high: got %0d want 10", last_high); end
        cmp_cnt++; if (last_level !== 4'd2)    begin err_cnt++; $display("FAIL steady_level: got %0d want 2", last_level); end
        cmp_cnt++; if (stuck_seen)             begin err_cnt++; $display("FAIL steady_stuck: got 1 want 0"); end
    endtask

    task automatic test_level_saturation();
        clear_mon();
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 70);
            drive(1'b0, 10);
        end
        cmp_cnt++; if (pulses != 3)            begin err_cnt++; $display("FAIL sat_pulse_count: got %0d want 3", pulses); end
        cmp_cnt++; if (last_period !== 8'd80)  begin err_cnt++; $display("FAIL sat_period: got %0d want 80", last_period); end
        cmp_cnt++; if (last_high !== 8'd70)    begin err_cnt++; $display("FAIL sat_high: got %0d want 70", last_high); end
        cmp_cnt++; if (last_level !== 4'd15)   begin err_cnt++; $display("FAIL sat_level: got %0d want 15", last_level); end
    endtask

    task automatic test_stuck_low();
        do_reset();
        drive(1'b0, 120);
        cmp_cnt++; if (stuck_first_cyc != 101) begin err_cnt++; $display("FAIL stuck_low_onset: got %0d want 101", stuck_first_cyc); end
        cmp_cnt++; if (stuck_o !== 1'b1)       begin err_cnt++; $display("FAIL stuck_low_level: got %b want 1", stuck_o); end
        cmp_cnt++; if (pulses != 0)            begin err_cnt++; $display("FAIL stuck_low_pulses: got %0d want 0", pulses); end
        clear_mon();
        drive(1'b1, 10);
        cmp_cnt++; if (stuck_o !== 1'b0)       begin err_cnt++; $display("FAIL stuck_low_release: got %b want 0", stuck_o); end
        cmp_cnt++; if (pulses != 0)            begin err_cnt++; $display("FAIL stuck_low_first_rise_pulse: got %0d want 0", pulses); end
        drive(1'b0, 30);
        drive(1'b1, 10);
        cmp_cnt++; if (pulses != 1)            begin err_cnt++; $display("FAIL stuck_low_recover_pulses: got %0d want 1", pulses); end
        cmp_cnt++; if (last_period !== 8'd40)  begin err_cnt++; $display("FAIL stuck_low_recover_period: got %0d want 40", last_period); end
        cmp_cnt++; if (last_high !== 8'd10)    begin err_cnt++; $display("FAIL stuck_low_recover_high: got %0d want 10", last_high); end
    endtask

    task automatic test_stuck_high();
        clear_mon();
        drive(1'b1, 110);
        cmp_cnt++; if (stuck_o !== 1'b1)       begin err_cnt++; $display("FAIL stuck_high_level: got %b want 1", stuck_o); end
        cmp_cnt++; if (period_o !== 8'd40)     begin err_cnt++; $display("FAIL stuck_high_hold_period: got %0d want 40", period_o); end
        cmp_cnt++; if (high_o !== 8'd10)       begin err_cnt++; $display("FAIL stuck_high_hold_high: got %0d want 10", high_o); end
        cmp_cnt++; if (level_o !== 4'd2)       begin err_cnt++; $display("FAIL stuck_high_hold_level: got %0d want 2", level_o); end
        cmp_cnt++; if (pulses != 0)            begin err_cnt++; $display("FAIL stuck_high_pulses: got %0d want 0", pulses); end
        drive(1'b0, 20);
        clear_mon();
        drive(1'b1, 10);
        drive(1'b0, 30);
        drive(1'b1, 10);
        cmp_cnt++; if (pulses != 1)            begin err_cnt++; $display("FAIL stuck_high_recover_pulses: got %0d want 1", pulses); end
        cmp_cnt++; if (last_period !== 8'd40)  begin err_cnt++; $display("FAIL stuck_high_recover_period: got %0d want 40", last_period); end
        cmp_cnt++; if (stuck_o !== 1'b0)       begin err_cnt++; $display("FAIL stuck_high_recover_stuck: got %b want 0", stuck_o); end
    endtask

    task automatic test_min_pulse_and_boundary();
        drive(1'b0, 10);
        clear_mon();
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 1);
            drive(1'b0, 19);
        end
        cmp_cnt++; if (pulses != 4)            begin err_cnt++; $display("FAIL min_pulse_count: got %0d want 4", pulses); end
        cmp_cnt++; if (last_period !== 8'd20)  begin err_cnt++; $display("FAIL min_pulse_period: got %0d want 20", last_period); end
        cmp_cnt++; if (last_high !== 8'd1)     begin err_cnt++; $display("FAIL min_pulse_high: got %0d want 1", last_high); end
        cmp_cnt++; if (last_level !== 4'd0)    begin err_cnt++; $display("FAIL min_pulse_level: got %0d want 0", last_level); end
        clear_mon();
        drive(1'b1, 1);
        drive(1'b0, 99);
        drive(1'b1, 1);
        drive(1'b0, 5);
        cmp_cnt++; if (pulses != 2)            begin err_cnt++; $display("FAIL edge100_pulses: got %0d want 2", pulses); end
        cmp_cnt++; if (last_period !== 8'd100) begin err_cnt++; $display("FAIL edge100_period: got %0d want 100", last_period); end
        cmp_cnt++; if (last_high !== 8'd1)     begin err_cnt++; $display("FAIL edge100_high: got %0d want 1", last_high); end
        cmp_cnt++; if (stuck_seen)             begin err_cnt++; $display("FAIL edge100_stuck: got 1 want 0"); end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b1, 5);
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if (period_o !== 8'd0)      begin err_cnt++; $display("FAIL midrst_period: got %0d want 0", period_o); end
        cmp_cnt++; if (high_o !== 8'd0)        begin err_cnt++; $display("FAIL midrst_high: got %0d want 0", high_o); end
        cmp_cnt++; if (pwm_sync_o !== 1'b0)    begin err_cnt++; $display("FAIL midrst_sync: got %b want 0", pwm_sync_o); end
        for (int i = 0; i < 4; i++) begin
            pwm_in = ~pwm_in;
            @(posedge clk);
            #1;
            cmp_cnt++; if ({period_o, high_o, level_o, meas_valid_o, stuck_o, pwm_sync_o} !== 23'd0)
                begin err_cnt++; $display("FAIL midrst_hold_%0d: got p=%0d h=%0d l=%0d v=%b s=%b y=%b want all 0", i, period_o, high_o, level_o, meas_valid_o, stuck_o, pwm_sync_o); end
        end
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        clear_mon();
        drive(1'b0, 5);
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 10);
            drive(1'b0, 30);
        end
        drive(1'b1, 10);
        cmp_cnt++; if (first_pulse_cyc != 48)  begin err_cnt++; $display("FAIL midrst_first_pulse_cycle: got %0d want 48", first_pulse_cyc); end
        cmp_cnt++; if (pulses != 2)            begin err_cnt++; $display("FAIL midrst_pulses: got %0d want 2", pulses); end
        cmp_cnt++; if (last_period !== 8'd40)  begin err_cnt++; $display("FAIL midrst_period_after: got %0d want 40", last_period); end
    endtask

    initial begin
        clear_mon();
        last_period = '0;
        last_high   = '0;
        last_level  = '0;
        test_reset();
        test_steady();
        test_level_saturation();
        test_stuck_low();
        test_stuck_high();
        test_min_pulse_and_boundary();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the team's servo PWM generator. Samples an external PWM line and measures its period and high time in clk cycles. Quantizes the high time into the same 0-15 level scale the generator uses (level = high >> LEVEL_SHIFT). Flags a stuck line when no rising edge arrives within a timeout. Sits on the slave board between a PWM input pin and the control logic that consumes servo commands.

Parameters:
CNT_W, 21, width of period/high counters and outputs
TIMEOUT_CYC, 2_000_000, cycles without a rising edge before stuck_o asserts (40 ms at 50 MHz); must be < 2**CNT_W
LEVEL_SHIFT, 18, right shift from high time to level

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
pwm_in  in  1  asynchronous PWM line
period_o  out  CNT_W  last complete period, rising to rising, in cycles
high_o  out  CNT_W  high time of that period, in cycles
level_o  out  4  min(high_o >> LEVEL_SHIFT, 15)
meas_valid_o  out  1  one-cycle pulse when period_o/high_o/level_o update
stuck_o  out  1  no rising edge for TIMEOUT_CYC cycles
pwm_sync_o  out  1  synchronized pwm_in level

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Synchronizer: 2 flops, then a delay flop. rise = s2 & ~s3; fall = ~s2 & s3. pwm_sync_o = s2.
- Latency: a pwm_in change that is sampled at clk edge N produces a registered response at edge N+2. Counts are exact cycle counts of the synchronized waveform.
- p_cnt: loads 1 on every rise. Otherwise increments, saturating at TIMEOUT_CYC.
- FSM states: IDLE, HIGH, LOW, STUCK.
- IDLE: waits for the first rise; a partial first period is discarded.
  - rise -> HIGH.
  - p_cnt == TIMEOUT_CYC with no rise -> STUCK.
  - fall is ignored.
- HIGH:
  - fall -> latch high_tmp = p_cnt, go to LOW.
  - timeout -> STUCK.
- LOW:
  - rise -> period_o = p_cnt, high_o = high_tmp, level_o updated, meas_valid_o = 1 for one cycle, go to HIGH.
  - timeout -> STUCK.
- STUCK: stuck_o = 1; period_o/high_o/level_o hold their last values.
  - rise -> stuck_o = 0, go to HIGH.
  - fall -> stuck_o = 0, go to IDLE.
- Timeout rule: timeout means p_cnt == TIMEOUT_CYC and no rise in that cycle. A rise in the same cycle wins and yields a valid period of TIMEOUT_CYC.
- Level: computed from the latched high time; saturates at 15 if the shifted value exceeds 15.
- Minimum pulse: 1-cycle high or low pulses of the synchronized signal are measured correctly (high_o = 1).
- meas_valid_o never asserts in IDLE or STUCK, and never on the first rise after reset or after STUCK.
- Reset mid-measurement: immediate return to reset values; the next valid result needs two rises.

Decomposition:
- pwm_pkg: state enum (IDLE, HIGH, LOW, STUCK), PWM_PERIOD_CYC = 1_000_001, PWM_LEVEL_SHIFT = 18, PWM_TIMEOUT_CYC = 2_000_000. The generator re-uses these constants.
- Sub-module pwm_sync_edge: 2-flop synchronizer plus delay flop; outputs sync, rise, fall; async active-low reset.

Test Plan:
(Small-parameter instance for all scenarios: CNT_W=8, TIMEOUT_CYC=100, LEVEL_SHIFT=2.)
- Steady PWM, 10 cycles high / 30 low, synchronous to clk, 5 periods -> first meas_valid_o pulse on the 2nd rise (+2 edges), then period_o=40, high_o=10, level_o=2, one pulse per period, stuck_o=0.
- High 70 / low 10 -> period_o=80, high_o=70, level_o=15 (70>>2=17, saturated).
- Line held low after reset for 120 cycles -> stuck_o rises when p_cnt reaches 100, meas_valid_o never pulses. Next rise -> stuck_o=0; a valid result follows one period later.
- Line stuck high mid-run -> stuck_o=1 after 100 cycles since the last rise, outputs hold. Then a fall -> IDLE; the next two rises produce one valid result.
- 1-cycle high pulse every 20 cycles -> high_o=1, period_o=20, level_o=0. Rise landing exactly at p_cnt=100 -> period_o=100 and no stuck_o.
- rst_n asserted mid-HIGH with pwm_in toggling -> all outputs 0 immediately. After release, the first pulse arrives only at the 2nd rise.
